// File: rtl/mips_cpu_mem_master.sv
// rtl/mips_cpu_mem_master.sv - Avalon-MM data master for single MIPS load/store requests
module mips_cpu_mem_master #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic        write_q;
  logic [15:0] wait_cnt;

  logic        misaligned;
  logic [3:0]  be_req;
  logic [31:0] wdata_rep;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic        bus_timeout;

  always_comb begin
    misaligned = 1'b0;
    be_req     = 4'b1111;
    wdata_rep  = req_wdata;
    unique case (req_size)
      2'b00: begin
        be_req    = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_req     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{req_wdata[15:0]}};
        misaligned = req_addr[0];
      end
      default: misaligned = |req_addr[1:0];
    endcase
  end

  // Lane extraction uses the offset/size captured at acceptance, not the live request.
  always_comb begin
    lane_b = readdata[7:0];
    unique case (off_q)
      2'd0: lane_b = readdata[7:0];
      2'd1: lane_b = readdata[15:8];
      2'd2: lane_b = readdata[23:16];
      default: lane_b = readdata[31:24];
    endcase
    lane_h = off_q[1] ? readdata[31:16] : readdata[15:0];
    unique case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = readdata;
    endcase
  end

  assign bus_timeout = waitrequest && (wait_cnt >= WAIT_LAST);
  assign req_ready   = (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = misaligned ? RESP : BUS;
      BUS:     if (!waitrequest || bus_timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
      write_q    <= 1'b0;
      wait_cnt   <= 16'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      address    <= 32'd0;
      byteenable <= 4'd0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'd0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          size_q   <= req_size;
          signed_q <= req_signed;
          off_q    <= req_addr[1:0];
          write_q  <= req_write;
          wait_cnt <= 16'd0;
          if (misaligned) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            address    <= {req_addr[31:2], 2'b00};
            byteenable <= be_req;
            writedata  <= wdata_rep;
            read       <= !req_write;
            write      <= req_write;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= write_q ? 32'd0 : load_data;
          end else begin
            if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
            if (bus_timeout) begin
              read       <= 1'b0;
              write      <= 1'b0;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// tb/tb_mips_cpu_mem_master.sv - directed and randomized checks of the Avalon data master
`timescale 1ns/1ps
module tb_mips_cpu_mem_master;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  always #5 clk = ~clk;

  mips_cpu_mem_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  // Slave RAM with programmable wait states counted from the strobe's rising edge
  logic [31:0] mem     [0:255] = '{default: 32'd0};
  logic [31:0] ref_mem [0:255] = '{default: 32'd0};
  int cur_delay = 0;
  bit stuck = 1'b0;
  int cyc = 0;

  assign waitrequest = stuck || ((read || write) && (cyc < cur_delay));
  assign readdata    = mem[address[9:2]];

  always @(posedge clk) begin
    if (read || write) cyc <= cyc + 1; else cyc <= 0;
    if (write && !waitrequest)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[address[9:2]][8*i +: 8] <= writedata[8*i +: 8];
  end

  int both_cnt = 0, gap_viol = 0, low_run = 100;
  always @(posedge clk) begin
    if (read && write) both_cnt <= both_cnt + 1;
    if (read || write) begin
      if (low_run == 1) gap_viol <= gap_viol + 1;
      low_run <= 0;
    end else if (low_run < 1000) begin
      low_run <= low_run + 1;
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit m_mis(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return off[0];
    return off != 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'b0001 << off;
    if (sz == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {4{wd[7:0]}};
    if (sz == 2'b01) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int o;
    w = ref_mem[a[9:2]];
    o = int'(a[1:0]);
    if (sz == 2'b00) begin
      b = w[8*o +: 8];
      return sg ? {{24{b[7]}}, b} : {24'd0, b};
    end
    if (sz == 2'b01) begin
      h = (o == 2) ? w[31:16] : w[15:0];
      return sg ? {{16{h[15]}}, h} : {16'd0, h};
    end
    return w;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int o;
    o = int'(a[1:0]);
    if (sz == 2'b00) ref_mem[a[9:2]][8*o +: 8] = wd[7:0];
    else if (sz == 2'b01) ref_mem[a[9:2]][8*o +: 16] = wd[15:0];
    else ref_mem[a[9:2]] = wd;
  endtask

  logic [31:0] last_rdata, last_addr, last_wd;
  logic [3:0]  last_be;
  logic        last_err;
  int          last_lat, last_scyc;

  // One request from the IDLE negedge through the cycle after its response
  task automatic xact(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] ad,
                      input logic [31:0] wd, input int dly, input bit stk);
    bit mis, exp_err, got_w;
    logic [31:0] exp_rd;
    int exp_lat, exp_sc, n;
    mis     = m_mis(sz, ad[1:0]);
    exp_err = mis || stk;
    exp_rd  = (wr || exp_err) ? 32'd0 : m_load(ad, sz, sg);
    exp_lat = mis ? 1 : (stk ? TMO + 1 : dly + 2);
    exp_sc  = mis ? 0 : (stk ? TMO : dly + 1);
    cur_delay = dly;
    stuck     = stk;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr  = ad;   req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_signed = ~sg;
    req_addr = $urandom; req_wdata = $urandom;
    last_lat = 1; last_scyc = 0; got_w = 1'b0;
    last_addr = 32'd0; last_be = 4'd0; last_wd = 32'd0;
    while (!resp_valid && last_lat < 100) begin
      if (read || write) begin
        if (last_scyc == 0) begin
          last_addr = address; last_be = byteenable; last_wd = writedata; got_w = write;
        end
        last_scyc++;
      end
      @(negedge clk);
      last_lat++;
    end
    check("resp_seen", 32'(resp_valid), 32'd1);
    last_rdata = resp_rdata;
    last_err   = resp_error;
    check("resp_error", 32'(resp_error), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("latency", 32'(last_lat), 32'(exp_lat));
    check("strobe_cycles", 32'(last_scyc), 32'(exp_sc));
    if (!mis) begin
      check("address", last_addr, {ad[31:2], 2'b00});
      check("byteenable", 32'(last_be), 32'(m_be(sz, ad[1:0])));
      check("direction", 32'(got_w), 32'(wr));
      if (wr) check("writedata", last_wd, m_wd(sz, wd));
    end
    if (wr && !exp_err) m_store(ad, sz, wd);
    stuck = 1'b0;
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
    check("rdata_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
    check("rst_writedata", writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xact(1'b1, 2'b10, 1'b0, 32'hBFC00010, 32'hDEADBEEF, 0, 1'b0);
    check("sw_be", 32'(last_be), 32'h0000000F);
    check("sw_wd", last_wd, 32'hDEADBEEF);
    xact(1'b0, 2'b10, 1'b0, 32'hBFC00010, 32'd0, 1, 1'b0);
    check("lw_data", last_rdata, 32'hDEADBEEF);
    check("lw_err", 32'(last_err), 32'd0);
    xact(1'b0, 2'b00, 1'b1, 32'hBFC00013, 32'd0, 2, 1'b0);
    check("lb_be", 32'(last_be), 32'h00000008);
    check("lb_data", last_rdata, 32'hFFFFFFDE);
    xact(1'b0, 2'b00, 1'b0, 32'hBFC00011, 32'd0, 0, 1'b0);
    check("lbu_data", last_rdata, 32'h000000BE);
    xact(1'b1, 2'b01, 1'b0, 32'hBFC00022, 32'h00001234, 3, 1'b0);
    check("sh_be", 32'(last_be), 32'h0000000C);
    check("sh_wd", last_wd, 32'h12341234);
    xact(1'b0, 2'b01, 1'b1, 32'hBFC00022, 32'd0, 0, 1'b0);
    check("lh_pos", last_rdata, 32'h00001234);
    xact(1'b1, 2'b01, 1'b0, 32'hBFC00022, 32'h00008001, 0, 1'b0);
    xact(1'b0, 2'b01, 1'b1, 32'hBFC00022, 32'd0, 4, 1'b0);
    check("lh_neg", last_rdata, 32'hFFFF8001);
    xact(1'b0, 2'b10, 1'b0, 32'hBFC00001, 32'd0, 0, 1'b0);
    check("mis_err", 32'(last_err), 32'd1);
    check("mis_lat", 32'(last_lat), 32'd1);
    check("mis_strobe", 32'(last_scyc), 32'd0);

    xact(1'b0, 2'b10, 1'b0, 32'hBFC00010, 32'd0, 0, 1'b1);
    check("tmo_err", 32'(last_err), 32'd1);
    check("tmo_strobe", 32'(last_scyc), 32'd8);

    cur_delay = 5;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'hBFC00010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_pre", 32'(read), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_read", 32'(read), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 2'b10, 1'b0, 32'hBFC00010, 32'd0, 1, 1'b0);
    check("rst_mid_after", last_rdata, 32'hDEADBEEF);

    for (int k = 0; k < 200; k++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 32'hBFC00000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        else if (sz[1]) ad[1:0] = 2'b00;
      end
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
           int'($urandom_range(0, 5)), 1'b0);
    end

    check("rw_never_both", 32'(both_cnt), 32'd0);
    check("strobe_gap", 32'(gap_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_master.md
# mips_cpu_mem_master

Avalon-MM master that turns single load/store requests from the MIPS CPU core into Avalon read/write transactions on the data bus. It handles byte-lane selection, store-data replication, load extraction and sign/zero extension, misalignment detection, and a bus timeout. It sits between the core's execute/memory stage and the Avalon memory (the testbench RAM model in simulation).

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum number of cycles `waitrequest` may stay high before the transaction is aborted with an error. Range 1..65535.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse: request completed
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualified by resp_valid: misaligned or timeout
- address  out  32  Avalon word address, `{req_addr[31:2], 2'b00}`
- byteenable  out  4  Avalon lane enables
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- writedata  out  32  Avalon write data
- waitrequest  in  1  Avalon stall
- readdata  in  32  Avalon read data; disabled lanes may read as 0

## Operation
- Little-endian: byte offset k = `req_addr[1:0]` maps to byteenable bit k and data bits [8k+7:8k].
- Byteenable: byte gives `4'b0001 << k`; halfword at k=0 gives 0011, at k=2 gives 1100; word gives 1111.
- Misaligned: a halfword with `addr[0]`=1 or a word with `addr[1:0]`≠0. No bus cycle is issued; the block goes straight to RESP with resp_error=1 and resp_rdata=0.
- Store data: byte is `{4{wdata[7:0]}}`; halfword is `{2{wdata[15:0]}}`; word is wdata unchanged.
- Load data: select the lane(s) by offset, then sign- or zero-extend to 32 bits per req_signed. Word loads ignore req_signed.
- All request fields are registered on acceptance. Later changes on req_* do not affect the transaction in flight.
- States:
  - IDLE: req_ready=1. When req_valid=1, go to BUS, or to RESP if the request is misaligned.
  - BUS: read or write held high, and address, byteenable and writedata held stable. When waitrequest=0 is sampled, capture readdata and go to RESP. When the wait counter reaches TIMEOUT_CYCLES, go to RESP with error.
  - RESP: resp_valid=1 for exactly one cycle, strobes low, then go to IDLE.
- The wait counter clears on entry to BUS and increments on every BUS cycle with waitrequest=1. It is 16 bits wide and saturates.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; req_ready=1; read, write and resp_valid at 0; resp_rdata, resp_error, address, byteenable and writedata all 0; counter 0. Reset aborts any in-flight transaction. Strobes are low in the first cycle after reset.
- Accept in cycle T: the strobe is high from T+1. If waitrequest is sampled low in cycle T+n (n≥1), resp_valid is high in T+n+1 and req_ready is high again in T+n+2. The minimum accept-to-response latency is 2 cycles.
- Misaligned request accepted in T: resp_valid in T+1, with no strobe at any point.
- Between two transactions the strobes are low for at least 2 cycles (RESP and IDLE). This guarantees the rising strobe edge the slave uses to start waitrequest.
- read and write are never high together. Strobes are registered outputs.
- Timeout: strobe drops in the cycle after the counter hits TIMEOUT_CYCLES; resp_valid and resp_error go high in that same cycle.
- resp_rdata and resp_error hold their values after the RESP pulse until the next response.

## Test plan
- Word store then load: store 0xDEADBEEF to 0xBFC00010 → write with byteenable=1111 and writedata=0xDEADBEEF. Load word from 0xBFC00010 → resp_rdata=0xDEADBEEF, resp_error=0.
- Byte lanes: after the word above, load signed byte at 0xBFC00013 → byteenable=1000, resp_rdata=0xFFFFFFDE. Load unsigned byte at 0xBFC00011 → resp_rdata=0x000000BE.
- Halfword store/load: store halfword 0x1234 at 0xBFC00022 → byteenable=1100, writedata=0x12341234. Signed load halfword from the same address → 0x00001234. Store 0x8001 there, then signed load → 0xFFFF8001.
- Misalignment: load word at 0xBFC00001 → no read strobe, resp_valid one cycle after acceptance, resp_error=1, resp_rdata=0.
- Wait states and back-to-back: slave waitrequest held 0..5 cycles at random over 200 mixed requests → data matches a reference model, strobes are low ≥2 cycles between transactions, and read/write are never both high.
- Timeout and reset: TIMEOUT_CYCLES=8 with waitrequest stuck at 1 → strobe drops and resp_error=1 after 8 wait cycles. Separately, assert rst_n=0 mid-BUS → read=0 next cycle, req_ready=1, and the next request completes normally.
